// File: rtl/ram_bus_sequencer.sv
// Purpose: registered front end for an async 16-bit RAM; single-word read/write requests via valid/ready.
// Latency: read response READ_WAIT edges after acceptance; a write keeps the sequencer busy for WRITE_PULSE+2 cycles.
// Backpressure: o_reqReady is high only in IDLE; there is no request queue and no response backpressure.
// Optional: define RAM_SEQ_WRITE_ACK_EN to return a response pulse carrying the written data when a write completes.
module ram_bus_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 1
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_reqValid,
  output logic              o_reqReady,
  input  logic              i_reqWrite,
  input  logic [ADDR_W-1:0] i_reqAddr,
  input  logic [DATA_W-1:0] i_reqWdata,
  output logic              o_rspValid,
  output logic [DATA_W-1:0] o_rspData,
  output logic [ADDR_W-1:0] o_ramAddress,
  output logic              o_ramWriteNEn,
  output logic [DATA_W-1:0] o_ramWriteData,
  input  logic [DATA_W-1:0] i_ramReadData,
  output logic              o_ramNoe
);

  // Both counters are 4 bits wide, so only 1..15 can be represented.
  generate
    if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
      $error("ram_bus_sequencer: READ_WAIT must be in 1..15");
    end
    if (WRITE_PULSE < 1 || WRITE_PULSE > 15) begin : g_bad_write_pulse
      $error("ram_bus_sequencer: WRITE_PULSE must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] RD_INIT = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_INIT = 4'(WRITE_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_n_nxt;
  logic              noe_nxt;
  logic              rsp_vld_nxt;
  logic [DATA_W-1:0] rsp_dat_nxt;

  // Ready comes straight from the state register, so it never depends on the request inputs.
  assign o_reqReady = (state == IDLE);

  // State register plus every RAM pin and response output; reset forces the bus idle at once.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      o_ramAddress   <= '0;
      o_ramWriteData <= '0;
      o_ramWriteNEn  <= 1'b1;
      o_ramNoe       <= 1'b1;
      o_rspValid     <= 1'b0;
      o_rspData      <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      o_ramAddress   <= addr_nxt;
      o_ramWriteData <= wdata_nxt;
      o_ramWriteNEn  <= we_n_nxt;
      o_ramNoe       <= noe_nxt;
      o_rspValid     <= rsp_vld_nxt;
      o_rspData      <= rsp_dat_nxt;
    end
  end

  // Next state and next pin values. Strobes default to inactive; address, data and response hold.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = o_ramAddress;
    wdata_nxt   = o_ramWriteData;
    we_n_nxt    = 1'b1;
    noe_nxt     = 1'b1;
    rsp_vld_nxt = 1'b0;
    rsp_dat_nxt = o_rspData;
    case (state)
      IDLE: begin
        if (i_reqValid) begin
          addr_nxt = i_reqAddr;
          if (i_reqWrite) begin
            wdata_nxt = i_reqWdata;
            state_nxt = WR_SETUP;
          end else begin
            noe_nxt   = 1'b0;
            cnt_nxt   = RD_INIT;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
          noe_nxt = 1'b0;
        end else begin
          // Sample the RAM on the last edge of the output-enable window.
          rsp_dat_nxt = i_ramReadData;
          rsp_vld_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WR_SETUP: begin
        // Address and data have now been stable for a full cycle, so the pulse can start.
        we_n_nxt  = 1'b0;
        cnt_nxt   = WR_INIT;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt != 4'd0) begin
          cnt_nxt  = cnt - 4'd1;
          we_n_nxt = 1'b0;
        end else begin
          state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: begin
        state_nxt = IDLE;
`ifdef RAM_SEQ_WRITE_ACK_EN
        rsp_vld_nxt = 1'b1;
        rsp_dat_nxt = o_ramWriteData;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bus_sequencer.sv
// Purpose: directed checks of ram_bus_sequencer pin timing for reads, writes, back-to-back requests and reset.
// Latency: inputs are driven 1 time unit after a rising edge, and outputs are sampled at that same point.
// Backpressure: requests are presented only when the bench expects ready; busy-cycle input changes must be ignored.
module tb_ram_bus_sequencer;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid3 = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;

  logic        req_ready, rsp_valid, ram_we_n, ram_noe;
  logic [15:0] rsp_data, ram_addr, ram_wdata, ram_rdata;

  logic        req_ready3, rsp_valid3, ram_we_n3, ram_noe3;
  logic [15:0] rsp_data3, ram_addr3, ram_wdata3;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  // Expected values that change when the write-ack feature is built in.
`ifdef RAM_SEQ_WRITE_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  always #5 clk = ~clk;

  ram_bus_sequencer #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(2), .WRITE_PULSE(1)) u_dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_reqValid(req_valid), .o_reqReady(req_ready),
    .i_reqWrite(req_write), .i_reqAddr(req_addr), .i_reqWdata(req_wdata),
    .o_rspValid(rsp_valid), .o_rspData(rsp_data),
    .o_ramAddress(ram_addr), .o_ramWriteNEn(ram_we_n), .o_ramWriteData(ram_wdata),
    .i_ramReadData(ram_rdata), .o_ramNoe(ram_noe)
  );

  // A second instance with a longer pulse, used for the mid-pulse reset case; its RAM always returns 0x5A5A.
  ram_bus_sequencer #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(2), .WRITE_PULSE(3)) u_dut3 (
    .i_clk(clk), .i_nrst(nrst),
    .i_reqValid(req_valid3), .o_reqReady(req_ready3),
    .i_reqWrite(req_write), .i_reqAddr(req_addr), .i_reqWdata(req_wdata),
    .o_rspValid(rsp_valid3), .o_rspData(rsp_data3),
    .o_ramAddress(ram_addr3), .o_ramWriteNEn(ram_we_n3), .o_ramWriteData(ram_wdata3),
    .i_ramReadData(16'h5A5A), .o_ramNoe(ram_noe3)
  );

  // Async RAM model: the read port drives data while output enable is low, and a write lands on the
  // trailing (rising) edge of the write-enable pulse.
  logic [15:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
  assign ram_rdata = ram_noe ? 16'h0000 : mem[ram_addr];
  always @(posedge ram_we_n) mem[ram_addr] = ram_wdata;

  // The write and output-enable strobes must never be low together.
  always @(negedge clk) if (!ram_we_n && !ram_noe) overlap++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted mid-cycle, before any clock edge: outputs must settle immediately.
    #3 nrst = 1'b0;
    #1;
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_noe", ram_noe, 1);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_wdata", ram_wdata, 16'h0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    tick();
    tick();
    #3 nrst = 1'b1;
    tick();

    // Write 0xBEEF to 0x1234: one setup cycle, one pulse cycle, one hold cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    chk("wr_setup_ready", req_ready, 0);
    chk("wr_setup_we_n", ram_we_n, 1);
    chk("wr_setup_addr", ram_addr, 16'h1234);
    chk("wr_setup_data", ram_wdata, 16'hBEEF);
    tick();
    chk("wr_pulse_we_n", ram_we_n, 0);
    chk("wr_pulse_noe", ram_noe, 1);
    chk("wr_pulse_ready", req_ready, 0);
    tick();
    chk("wr_hold_we_n", ram_we_n, 1);
    chk("wr_hold_ready", req_ready, 0);
    chk("wr_hold_addr", ram_addr, 16'h1234);
    chk("wr_hold_data", ram_wdata, 16'hBEEF);
    tick();
    chk("wr_done_ready", req_ready, 1);
    chk("wr_done_rsp_valid", rsp_valid, ACK);
    chk("wr_done_rsp_data", rsp_data, ACK ? 16'hBEEF : 16'h0000);
    chk("wr_mem", mem[16'h1234], 16'hBEEF);
    tick();

    // Read back 0x1234: output enable low for two cycles, response on the second edge.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
    tick();
    req_valid = 1'b0;
    chk("rd_acc_noe", ram_noe, 0);
    chk("rd_acc_ready", req_ready, 0);
    chk("rd_acc_rsp_valid", rsp_valid, 0);
    tick();
    chk("rd_wait_noe", ram_noe, 0);
    chk("rd_wait_rsp_valid", rsp_valid, 0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 16'hBEEF);
    chk("rd_rsp_noe", ram_noe, 1);
    chk("rd_rsp_ready", req_ready, 1);
    tick();
    chk("rd_pulse_end", rsp_valid, 0);
    chk("rd_data_hold", rsp_data, 16'hBEEF);

    // Back-to-back with valid held: a read of 0x0000, then a write 0xFFFF=0x0001 accepted in the response cycle.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
    tick();
    req_write = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'h0001;
    chk("b2b_rd_noe", ram_noe, 0);
    tick();
    chk("b2b_busy_addr", ram_addr, 16'h0000);
    chk("b2b_busy_we_n", ram_we_n, 1);
    tick();
    chk("b2b_rd_rsp_valid", rsp_valid, 1);
    chk("b2b_rd_rsp_data", rsp_data, 16'h0000);
    chk("b2b_rsp_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_wr_ready", req_ready, 0);
    chk("b2b_wr_addr", ram_addr, 16'hFFFF);
    chk("b2b_wr_data", ram_wdata, 16'h0001);
    chk("b2b_wr_rsp_valid", rsp_valid, 0);
    tick();
    chk("b2b_pulse_we_n", ram_we_n, 0);
    chk("b2b_pulse_noe", ram_noe, 1);
    tick();
    chk("b2b_hold_we_n", ram_we_n, 1);
    tick();
    chk("b2b_done_ready", req_ready, 1);
    chk("b2b_done_rsp_valid", rsp_valid, ACK);
    chk("b2b_mem_ffff", mem[16'hFFFF], 16'h0001);
    chk("b2b_overlap", overlap, 0);
    tick();

    // Write 0x00AA to 0x0010: a response appears after the hold cycle only when the ack feature is built in.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h00AA;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("ack_hold_rsp_valid", rsp_valid, 0);
    tick();
    chk("ack_rsp_valid", rsp_valid, ACK);
    chk("ack_rsp_data", rsp_data, ACK ? 16'h00AA : 16'h0000);
    tick();
    chk("ack_pulse_end", rsp_valid, 0);

    // Reset in the middle of a three-cycle write pulse on the second instance.
    req_valid3 = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h1111;
    tick();
    req_valid3 = 1'b0;
    tick();
    chk("mid_pulse_we_n_a", ram_we_n3, 0);
    tick();
    chk("mid_pulse_we_n_b", ram_we_n3, 0);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_we_n", ram_we_n3, 1);
    chk("mid_rst_ready", req_ready3, 1);
    chk("mid_rst_rsp_valid", rsp_valid3, 0);
    #1 nrst = 1'b1;
    tick();
    chk("post_rst_rsp_valid", rsp_valid3, 0);
    chk("post_rst_we_n", ram_we_n3, 1);
    req_valid3 = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
    tick();
    req_valid3 = 1'b0;
    chk("post_rst_rd_noe", ram_noe3, 0);
    chk("post_rst_rd_addr", ram_addr3, 16'h0040);
    tick();
    chk("post_rst_rd_wait", rsp_valid3, 0);
    tick();
    chk("post_rst_rd_rsp_valid", rsp_valid3, 1);
    chk("post_rst_rd_rsp_data", rsp_data3, 16'h5A5A);
    chk("final_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
